// File: rtl/onewire_master_ctrl.sv
// 1-Wire bus master: RESET/presence, byte write and byte read slots, LSB first.
// One command at a time; a one-cycle completion pulse carries the result.
`timescale 1ns/1ps
module onewire_master_ctrl #(
  parameter int unsigned CLK_PER_US = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       onewire_in,
  output logic       drive_low,
  output logic       busy,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence
);

  localparam int unsigned K  = CLK_PER_US;
  localparam int unsigned CW = $clog2(960 * K);

  localparam logic [CW-1:0] C_RST_LAST  = CW'(960 * K - 1);
  localparam logic [CW-1:0] C_RST_LOW   = CW'(480 * K);
  localparam logic [CW-1:0] C_PRES      = CW'(550 * K);
  localparam logic [CW-1:0] C_SLOT_LAST = CW'(70 * K - 1);
  localparam logic [CW-1:0] C_TLOW_1    = CW'(6 * K);
  localparam logic [CW-1:0] C_TLOW_0    = CW'(60 * K);
  localparam logic [CW-1:0] C_RD_SAMPLE = CW'(15 * K);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RST  = 2'd1;
  localparam logic [1:0] S_SLOT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  logic [1:0]    r_state, w_state_n;
  logic          r_pend;
  logic [1:0]    r_op;
  logic [7:0]    r_data;
  logic [7:0]    r_shift;
  logic [7:0]    r_rsp_data;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_bit, w_bit_n;
  logic          r_presence;
  logic          r_rsp_presence;
  logic          r_drive_low, w_drive_n;
  logic [CW-1:0] w_tlow;
  logic          w_ready;

  // The accepted command spends one cycle in a latch stage (r_pend) inside
  // IDLE before the phase starts; cmd_ready is withheld during that cycle.
  assign w_ready      = (r_state == S_IDLE) && !r_pend;
  assign cmd_ready    = w_ready;
  assign busy         = !w_ready;
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_data     = r_rsp_data;
  assign rsp_presence = r_rsp_presence;
  assign drive_low    = r_drive_low;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_cnt_n = '0;
          w_bit_n = '0;
          case (r_op)
            OP_RESET:         w_state_n = S_RST;
            OP_WRITE, OP_READ: w_state_n = S_SLOT;
            default:          w_state_n = S_RESP;
          endcase
        end
      end
      S_RST: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_n = S_RESP;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_SLOT: begin
        if (r_cnt == C_SLOT_LAST) begin
          w_cnt_n = '0;
          if (r_bit == 3'd7) w_state_n = S_RESP;
          else               w_bit_n   = r_bit + 1'b1;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    // drive_low is registered, so it is derived from next-cycle state/counter
    w_tlow    = (r_op == OP_WRITE && !r_data[w_bit_n]) ? C_TLOW_0 : C_TLOW_1;
    w_drive_n = ((w_state_n == S_RST)  && (w_cnt_n < C_RST_LOW)) ||
                ((w_state_n == S_SLOT) && (w_cnt_n < w_tlow));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pend         <= 1'b0;
      r_op           <= '0;
      r_data         <= '0;
      r_shift        <= '0;
      r_cnt          <= '0;
      r_bit          <= '0;
      r_presence     <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_presence <= 1'b0;
      r_drive_low    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_bit       <= w_bit_n;
      r_drive_low <= w_drive_n;
      r_pend      <= cmd_valid && w_ready;
      if (cmd_valid && w_ready) begin
        r_op   <= cmd_op;
        r_data <= cmd_data;
      end
      if (r_state == S_RST && r_cnt == C_PRES)
        r_presence <= !onewire_in;
      if (r_state == S_SLOT && r_op == OP_READ && r_cnt == C_RD_SAMPLE)
        r_shift[r_bit] <= onewire_in;
      if (w_state_n == S_RESP && r_state != S_RESP) begin
        r_rsp_data     <= (r_op == OP_READ)  ? r_shift : '0;
        r_rsp_presence <= (r_op == OP_RESET) ? r_presence : 1'b0;
      end
    end
  end

endmodule

// File: doc/onewire_master_ctrl.md
ONEWIRE_MASTER_CTRL -- requirements
Module: onewire_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 27: clk cycles per microsecond, written K below.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1: controller is idle and will accept a command.
REQ-006 SHALL have port cmd_op, input, 2: 00 = RESET, 01 = WRITE_BYTE, 10 = READ_BYTE, 11 = NOP.
REQ-007 SHALL have port cmd_data, input, 8: the byte for WRITE_BYTE; ignored for other ops.
REQ-008 SHALL have port onewire_in, input, 1: the bus level, already synchronised.
REQ-009 SHALL have port drive_low, output, 1: 1 = pull the bus low; 0 = release it.
REQ-010 SHALL have port busy, output, 1: the inverse of cmd_ready.
REQ-011 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port rsp_data, output, 8: the byte read by READ_BYTE.
REQ-013 SHALL have port rsp_presence, output, 1: 1 = presence pulse detected during RESET.

Function
REQ-014 SHALL implement states IDLE, RST_PH, SLOT, RESP; cmd_ready = 1 only in IDLE.
REQ-015 SHALL accept a command on a clock edge where cmd_valid and cmd_ready are both 1, and SHALL latch cmd_op and cmd_data at that edge.
REQ-016 SHALL, in the cycle after acceptance, enter RST_PH (RESET), SLOT (WRITE_BYTE or READ_BYTE) or RESP (NOP), with phase counter = 0 and bit index = 0.
REQ-017 SHALL use a phase counter wide enough for 960*K-1 (15 bits at K = 27), incrementing once per cycle inside RST_PH and SLOT.
REQ-018 SHALL drive RST_PH as follows:
- drive_low = 1 while counter < 480*K;
- drive_low = 0 from counter 480*K to 960*K-1;
- sample onewire_in when counter == 550*K and set presence = !onewire_in;
- go to RESP after the counter == 960*K-1 cycle (960*K cycles in total).
REQ-019 SHALL make each SLOT 70*K cycles long, with drive_low = 1 while counter < T_low and 0 afterwards.
REQ-020 SHALL use T_low = 6*K for a write of 1 and for every read, and T_low = 60*K for a write of 0.
REQ-021 SHALL send and receive bits LSB first; bit i of a write comes from cmd_data[i].
REQ-022 SHALL, during a read, sample onewire_in at counter == 15*K into shift-register bit i.
REQ-023 SHALL, at counter == 70*K-1, reset the counter to 0; if bit index < 7 it SHALL increment the index and stay in SLOT, and if bit index == 7 it SHALL go to RESP; there SHALL be no gap cycle between slots.
REQ-024 SHALL spend exactly one cycle in RESP with rsp_valid = 1, then return to IDLE.
REQ-025 SHALL set response fields in RESP per operation:
- RESET: rsp_presence = sampled value, rsp_data = 0.
- READ_BYTE: rsp_data = assembled byte, rsp_presence = 0.
- WRITE_BYTE and NOP: rsp_data = 0, rsp_presence = 0.
REQ-026 SHALL hold rsp_data and rsp_presence stable until the next RESP cycle.
REQ-027 SHALL ignore cmd_valid while not in IDLE; no command SHALL be queued.
REQ-028 SHALL make drive_low a registered output that is never 1 in IDLE or RESP.
REQ-029 SHALL, on a command offered in the RESP cycle, not accept it; acceptance is earliest on the following IDLE cycle.
REQ-030 SHALL take 8*70*K + 2 cycles from the accept edge to the rsp_valid cycle for a byte op, and 960*K + 2 cycles for RESET.

Reset
REQ-031 SHALL, on rst = 1 at a clock edge, go to IDLE and set drive_low = 0, rsp_valid = 0, rsp_data = 0, rsp_presence = 0, counter = 0 and bit index = 0.
REQ-032 SHALL, when rst is asserted mid-operation, abort the operation without producing a response; the bus SHALL be released on the next edge.
REQ-033 SHALL give rst priority over any command offered in the same cycle.

Verification (K = 27)
REQ-034 SHALL cover RESET with onewire_in pulled low by the model from 500 us to 620 us -> drive_low high for 12960 cycles, then low; rsp_valid pulse with rsp_presence = 1.
REQ-035 SHALL cover RESET with onewire_in held at 1 -> rsp_presence = 0; rsp_valid occurs 25922 cycles after the accept edge.
REQ-036 SHALL cover WRITE_BYTE with cmd_data = 8'hA5 -> low-pulse widths 162, 1620, 162, 1620, 1620, 162, 1620, 162 cycles; slot starts 1890 cycles apart; rsp_data = 0.
REQ-037 SHALL cover READ_BYTE with the model holding onewire_in low through the sample point in slots 1, 2 and 6 only -> rsp_data = 8'hB9; every low pulse is 162 cycles.
REQ-038 SHALL cover rst asserted at slot 3, counter 100, of a WRITE_BYTE of 8'h00 -> drive_low = 0 on the next edge, no rsp_valid, cmd_ready = 1 on the following cycle; a new RESET is then accepted normally.
REQ-039 SHALL cover cmd_valid held high continuously with NOP -> rsp_valid every 3rd cycle; cmd_ready is never 1 in the RESP cycle; drive_low stays 0.
